bar_fifo: RTL and testbench
===========================

BAR_FIFO -- requirements
Module: bar_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of 32-bit entries; SHALL be a power of two, at least 2.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: x  bar.in  --  upstream stream; x.data[31:0] and x.valid are inputs, x.ready is an output.
REQ-005 Port: y  bar.out  --  downstream stream; y.data[31:0] and y.valid are outputs, y.ready is an input.
REQ-006 Port: level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-007 Push: x.valid && x.ready at a clock edge SHALL write x.data into the tail entry.
REQ-008 Pop: y.valid && y.ready at a clock edge SHALL retire the head entry.
REQ-009 Handshake: a source SHALL hold data/valid stable until accepted; the block SHALL never drop y.valid or change y.data before a pop.
REQ-010 x.ready SHALL be (level != DEPTH) and rst_n high.
- Driven from registered state only, never from x.valid or y.ready.
REQ-011 y.valid SHALL be (level != 0) and y.data SHALL equal the head entry.
- Both from registered state only; no combinational x-to-y path.
REQ-012 Latency: a word pushed into an empty FIFO SHALL appear on y one cycle after the push edge; there is no bypass.
REQ-013 Full: x.ready = 0, no push occurs, and a simultaneous pop SHALL make x.ready = 1 on the next cycle.
REQ-014 Empty: y.valid = 0, y.ready is ignored, and level SHALL stay 0.
REQ-015 Simultaneous push and pop with 0 < level < DEPTH: level SHALL be unchanged and both pointers SHALL advance.
REQ-016 level SHALL increment on push-only, decrement on pop-only, and be unchanged otherwise.
REQ-017 Pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap or stall.
REQ-018 Ordering: words SHALL exit in exactly push order; no reordering, duplication or loss.
REQ-019 State is two states derived from level (EMPTY, NONEMPTY/FULL); no separate FSM register is required.

Reset
REQ-020 While rst_n = 0 at a clock edge: wr_ptr, rd_ptr and level SHALL clear to 0, and all storage entries SHALL clear to 32'h0.
REQ-021 Output values in and after reset: x.ready = 0 while rst_n is low, and 1 on the first cycle after release; y.valid = 0; y.data = 32'h0; level = 0.
REQ-022 Reset mid-operation SHALL discard all stored words; no pop or push SHALL complete on a reset edge.

Structure
REQ-023 Package bar_pkg SHALL hold DATA_W = 32 and typedef word_t (logic [DATA_W-1:0]); interface bar and bar_fifo SHALL use word_t.
REQ-024 One sub-module SHALL be used: bar_fifo_ram, a DEPTH x word_t register array with one write port and one asynchronous read port.
REQ-025 Pointer, level and handshake logic SHALL live in bar_fifo; no latches and no multi-driven nets.

Verification
REQ-026 Reset then idle: rst_n low for 2 cycles, then high -> x.ready=0 during reset and 1 after, y.valid=0, y.data=0, level=0.
REQ-027 Single word: push 32'hDEADBEEF with y.ready=0 -> next cycle y.valid=1, y.data=DEADBEEF, level=1; y.ready=1 for one cycle -> y.valid=0, level=0.
REQ-028 Fill to full (DEPTH=4): push 1,2,3,4 with y.ready=0 -> level=4, x.ready=0; a fifth word held on x is not accepted; drain -> outputs 1,2,3,4 in order.
REQ-029 Full plus simultaneous pop: level=4, x.valid=1, y.ready=1 -> pop only that cycle, level=3, x.ready=1 next cycle.
REQ-030 Streaming wrap: x.valid=1 and y.ready=1 continuously with counting data for 3*DEPTH words -> level stays 1 in steady state, every word out in order, pointers wrap without a bubble.
REQ-031 Reset mid-stream: level=3, assert rst_n=0 for one cycle -> level=0, y.valid=0, y.data=0, and no stale word appears after release.

Source files
------------

// File: rtl/bar_pkg.sv
// rtl/bar_pkg.sv - shared word type and width for the bar FIFO
package bar_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/bar_if.sv
// rtl/bar_if.sv - valid/ready word stream with FIFO-side modports
interface bar
    import bar_pkg::*;
    ();

    word_t data;
    logic  valid;
    logic  ready;

    // Stream entering the FIFO: data/valid come in, ready goes out
    modport in (
        input  data,
        input  valid,
        output ready
    );

    // Stream leaving the FIFO: data/valid go out, ready comes in
    modport out (
        output data,
        output valid,
        input  ready
    );

endinterface

// File: rtl/bar_fifo_ram.sv
// rtl/bar_fifo_ram.sv - DEPTH x word_t register file, one write port, async read
module bar_fifo_ram
    import bar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  word_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output word_t                    rdata
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];

    // Next storage contents: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; reset wipes every entry so no stale word survives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bar_fifo.sv
// rtl/bar_fifo.sv - registered-output word FIFO between two valid/ready streams
module bar_fifo
    import bar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bar.in                         x,
    bar.out                        y,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push;
    logic          pop;
    word_t         head_word;

    // Handshakes depend only on registered occupancy (plus reset for ready)
    assign x.ready = rst_n && (level_q != FULL_LVL);
    assign y.valid = (level_q != '0);
    assign y.data  = head_word;
    assign level   = level_q;

    assign push = x.valid && x.ready;
    assign pop  = y.valid && y.ready;

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // Control state register; reset wins over any handshake on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    bar_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (x.data),
        .raddr (rd_ptr_q),
        .rdata (head_word)
    );

endmodule

// File: tb/tb_bar_fifo.sv
// tb/tb_bar_fifo.sv - self-checking bench for bar_fifo
module tb_bar_fifo;
    import bar_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] level;

    bar x_if ();
    bar y_if ();

    bar_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x_if),
        .y     (y_if),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic xv, input word_t xd, input logic yr);
        rst_n      = r;
        x_if.valid = xv;
        x_if.data  = xd;
        y_if.ready = yr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic  r;
        logic  xv;
        word_t xd;
        logic  yr;
        logic  e_xr;
        logic  e_yv;
        word_t e_yd;
        int    e_lv;
        logic  chk_d;
    } vec_t;

    vec_t tbl [20];

    // Reference model: a queue of words plus a flag saying storage is still all-zero
    word_t q[$];
    bit    clean;

    initial begin
        tbl[0]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1};
        tbl[1]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1};
        tbl[2]  = '{1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 1};
        tbl[3]  = '{1, 1, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 1, 1};
        tbl[4]  = '{1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0};
        tbl[5]  = '{1, 1, 32'd1,        0, 1, 1, 32'd1,        1, 1};
        tbl[6]  = '{1, 1, 32'd2,        0, 1, 1, 32'd1,        2, 1};
        tbl[7]  = '{1, 1, 32'd3,        0, 1, 1, 32'd1,        3, 1};
        tbl[8]  = '{1, 1, 32'd4,        0, 0, 1, 32'd1,        4, 1};
        tbl[9]  = '{1, 1, 32'd5,        0, 0, 1, 32'd1,        4, 1};
        tbl[10] = '{1, 1, 32'd5,        1, 1, 1, 32'd2,        3, 1};
        tbl[11] = '{1, 0, 32'h0,        1, 1, 1, 32'd3,        2, 1};
        tbl[12] = '{1, 0, 32'h0,        1, 1, 1, 32'd4,        1, 1};
        tbl[13] = '{1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0};
        tbl[14] = '{1, 1, 32'hA,        0, 1, 1, 32'hA,        1, 1};
        tbl[15] = '{1, 1, 32'hB,        0, 1, 1, 32'hA,        2, 1};
        tbl[16] = '{1, 1, 32'hC,        0, 1, 1, 32'hA,        3, 1};
        tbl[17] = '{0, 1, 32'hD,        1, 0, 0, 32'h0,        0, 1};
        tbl[18] = '{1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 1};
        tbl[19] = '{1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1};

        drive(0, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].r, tbl[i].xv, tbl[i].xd, tbl[i].yr);
            step();
            chk($sformatf("vec%0d_x_ready", i), 32'(x_if.ready), 32'(tbl[i].e_xr));
            chk($sformatf("vec%0d_y_valid", i), 32'(y_if.valid), 32'(tbl[i].e_yv));
            chk($sformatf("vec%0d_level", i), 32'(level), tbl[i].e_lv);
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d_y_data", i), y_if.data, tbl[i].e_yd);
            end
        end

        // Continuous streaming across several pointer wraps: one word in flight
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive(1, 1, 32'h100 + 32'(k), 1);
            step();
            chk($sformatf("stream%0d_level", k), 32'(level), 32'd1);
            chk($sformatf("stream%0d_y_data", k), y_if.data, 32'h100 + 32'(k));
            chk($sformatf("stream%0d_x_ready", k), 32'(x_if.ready), 32'd1);
        end
        drive(1, 0, '0, 1);
        step();
        chk("stream_drain_level", 32'(level), 32'd0);
        chk("stream_drain_y_valid", 32'(y_if.valid), 32'd0);

        // Randomised traffic against the queue model
        drive(0, 0, '0, 0);
        step();
        q.delete();
        clean = 1'b1;
        begin
            logic  r, xv, yr, m_push, m_pop;
            word_t xd;
            m_push = 1'b0;
            xv     = 1'b0;
            xd     = '0;
            for (int c = 0; c < 600; c++) begin
                r = ($urandom_range(0, 49) != 0);
                if (!(xv && !m_push)) begin
                    xv = ($urandom_range(0, 2) != 0);
                    xd = $urandom;
                end
                yr = ($urandom_range(0, 2) != 0);
                drive(r, xv, xd, yr);
                m_push = r && xv && (q.size() < DEPTH);
                m_pop  = r && yr && (q.size() > 0);
                step();
                if (!r) begin
                    q.delete();
                    clean = 1'b1;
                end else begin
                    if (m_pop) void'(q.pop_front());
                    if (m_push) begin
                        q.push_back(xd);
                        clean = 1'b0;
                    end
                end
                chk($sformatf("rnd%0d_x_ready", c), 32'(x_if.ready), 32'(r && (q.size() < DEPTH)));
                chk($sformatf("rnd%0d_y_valid", c), 32'(y_if.valid), 32'(q.size() > 0));
                chk($sformatf("rnd%0d_level", c), 32'(level), q.size());
                if (q.size() > 0) begin
                    chk($sformatf("rnd%0d_y_data", c), y_if.data, q[0]);
                end else if (clean) begin
                    chk($sformatf("rnd%0d_y_data_clr", c), y_if.data, 32'h0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
